// File: rtl/raster_to_block.sv
// raster_to_block: reorders raster-order pixels into 8x8 row-major blocks through ping-pong strip buffers
module raster_to_block #(
    parameter int IMG_WIDTH = 64,
    parameter int DATA_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] xin,
    output logic              xin_valid,
    output logic              blk_start,
    output logic              blk_last,
    output logic              strip_done
);
    localparam int N  = 8 * IMG_WIDTH;
    localparam int AW = $clog2(N);
    localparam int NB = IMG_WIDTH / 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] mem0 [N];
    logic [DATA_W-1:0] mem1 [N];
    logic [AW-1:0] wk, rd_addr;
    logic [1:0] full, full_nx;
    logic wb, rb, rd_bank, rd_v, rd_bs, rd_bl, rd_sd;
    logic [2:0] c, r;
    logic [BW-1:0] b;
    logic accept, wr_last, issue, rd_last;

    assign pix_ready = !full[wb] && !RST;

    always_comb begin
        accept   = pix_valid && pix_ready;
        wr_last  = wk == AW'(N - 1);
        issue    = state == READ || full[rb];
        rd_last  = issue && b == BW'(NB - 1) && r == 3'd7 && c == 3'd7;
        full_nx  = full;
        if (accept && wr_last) full_nx[wb] = 1'b1;
        if (rd_last) full_nx[rb] = 1'b0;
        state_nx = issue && (!rd_last || full[~rb]) ? READ : IDLE;
    end

    always_ff @(posedge CLK) begin
        if (accept && !wb) mem0[wk] <= pix_in;
        if (accept && wb) mem1[wk] <= pix_in;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            full       <= '0;
            wb         <= 1'b0;
            rb         <= 1'b0;
            wk         <= '0;
            c          <= '0;
            r          <= '0;
            b          <= '0;
            rd_v       <= 1'b0;
            rd_addr    <= '0;
            rd_bank    <= 1'b0;
            rd_bs      <= 1'b0;
            rd_bl      <= 1'b0;
            rd_sd      <= 1'b0;
            xin        <= '0;
            xin_valid  <= 1'b0;
            blk_start  <= 1'b0;
            blk_last   <= 1'b0;
            strip_done <= 1'b0;
        end else begin
            state <= state_nx;
            full  <= full_nx;
            if (accept) begin
                wk <= wr_last ? '0 : wk + 1'b1;
                wb <= wb ^ wr_last;
            end
            // c/r wrap naturally at 8, so only the block counter needs an explicit strip-end clear
            if (issue) begin
                c  <= c + 1'b1;
                r  <= c == 3'd7 ? r + 1'b1 : r;
                b  <= rd_last ? '0 : (r == 3'd7 && c == 3'd7) ? b + 1'b1 : b;
                rb <= rb ^ rd_last;
            end
            rd_v       <= issue;
            rd_bank    <= rb;
            rd_addr    <= AW'(int'(r) * IMG_WIDTH + int'(b) * 8 + int'(c));
            rd_bs      <= issue && r == 3'd0 && c == 3'd0;
            rd_bl      <= issue && r == 3'd7 && c == 3'd7;
            rd_sd      <= rd_last;
            xin_valid  <= rd_v;
            xin        <= rd_v ? (rd_bank ? mem1[rd_addr] : mem0[rd_addr]) : '0;
            blk_start  <= rd_bs;
            blk_last   <= rd_bl;
            strip_done <= rd_sd;
        end
    end
endmodule
